// File: rtl/sync_event_arbiter.sv
// Synchronizes asynchronous level inputs, flags each filtered level change and presents the
// changes one at a time through a round-robin valid/ready port. Define SYNC_EVENT_ARBITER_DEBOUNCE_EN for debounce filtering.
module sync_event_arbiter #(
    parameter int NUM_INPUTS      = 4,
    parameter int SYNC_DEPTH      = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic [NUM_INPUTS-1:0] enable,
    output logic                  event_valid,
    output logic [IW-1:0]         event_index,
    output logic                  event_level,
    input  logic                  event_ready,
    output logic [NUM_INPUTS-1:0] pending,
    output logic [NUM_INPUTS-1:0] overflow,
    input  logic [NUM_INPUTS-1:0] overflow_clear,
    output logic                  debug_state
);

    // Handshake: an event transfers on a clock edge where event_valid and event_ready are both 1;
    // while event_valid is 1, event_index and event_level hold until that transfer.

    localparam int JW = IW + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    if (NUM_INPUTS < 1 || NUM_INPUTS > 16) begin : g_bad_num_inputs
        $error("NUM_INPUTS must be within 1..16");
    end
    if (SYNC_DEPTH < 2 || SYNC_DEPTH > 4) begin : g_bad_sync_depth
        $error("SYNC_DEPTH must be within 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be within 1..65535");
    end

    state_t                  state;
    logic [NUM_INPUTS-1:0]   sync_q [SYNC_DEPTH];
    logic [NUM_INPUTS-1:0]   synced;
    logic [NUM_INPUTS-1:0]   filtered;
    logic [NUM_INPUTS-1:0]   prev_level;
    logic [NUM_INPUTS-1:0]   change;
    logic [NUM_INPUTS-1:0]   grant_mask;
    logic [NUM_INPUTS-1:0]   overflow_set;
    logic                    grant_found;
    logic [IW-1:0]           grant_idx;
    logic [IW-1:0]           pointer;
    logic [JW-1:0]           scan_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_DEPTH; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[SYNC_DEPTH-1];

`ifdef SYNC_EVENT_ARBITER_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]           db_cnt [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] filtered_q;

    // The counter tracks how long the synchronized level has disagreed with the filtered one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtered_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (synced[i] != filtered_q[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filtered_q[i] <= synced[i];
                        db_cnt[i]     <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign filtered = filtered_q;
`else
    assign filtered = synced;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_level <= '0;
        end else begin
            prev_level <= filtered;
        end
    end

    assign change = filtered ^ prev_level;

    // Round-robin scan: first pending bit at or above the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_idx = {1'b0, pointer} + JW'(k);
            if (scan_idx >= JW'(NUM_INPUTS)) begin
                scan_idx = scan_idx - JW'(NUM_INPUTS);
            end
            if (!grant_found && pending[scan_idx[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (state == IDLE && grant_found) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // A change arriving while the bit is still pending is lost, unless that bit is being granted now.
    assign overflow_set = enable & change & pending & ~grant_mask;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!enable[i]) begin
                    pending[i] <= 1'b0;
                end else if (change[i]) begin
                    pending[i] <= 1'b1;
                end else if (grant_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            overflow <= overflow_set | (overflow & ~overflow_clear);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            event_valid <= 1'b0;
            event_index <= '0;
            event_level <= 1'b0;
            pointer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        event_index <= grant_idx;
                        event_level <= filtered[grant_idx];
                        event_valid <= 1'b1;
                        state       <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (event_ready) begin
                        event_valid <= 1'b0;
                        if (event_index == IW'(NUM_INPUTS - 1)) begin
                            pointer <= '0;
                        end else begin
                            pointer <= event_index + IW'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    event_valid <= 1'b0;
                end
            endcase
        end
    end

    assign debug_state = (state == PRESENT);

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: directed scenarios plus random traffic, all compared each cycle
// against a behavioural model of the input history, change flags and round-robin presenter.
module tb_sync_event_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int DC = 8;
`ifdef SYNC_EVENT_ARBITER_DEBOUNCE_EN
    localparam int DB = DC;
`else
    localparam int DB = 0;
`endif
    localparam int SETTLE = D + 2 + DB;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] in_v = '0;
    logic [N-1:0] enable_v = '1;
    logic [N-1:0] ovc = '0;
    logic         ready_v = 1'b1;
    logic         event_valid;
    logic [1:0]   event_index;
    logic         event_level;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;
    logic         debug_state;

    int checks = 0;
    int failures = 0;
    int dut_log[$];

    sync_event_arbiter #(
        .NUM_INPUTS(N),
        .SYNC_DEPTH(D),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in(in_v),
        .enable(enable_v),
        .event_valid(event_valid),
        .event_index(event_index),
        .event_level(event_level),
        .event_ready(ready_v),
        .pending(pending),
        .overflow(overflow),
        .overflow_clear(ovc),
        .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_hist[$];   // input samples, newest first; the last one is the synchronized level
    logic [N-1:0] m_filt;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    int           m_run[N];
    bit           m_valid;
    int           m_idx;
    bit           m_level;
    int           m_ptr;

    task automatic model_reset();
        m_hist.delete();
        repeat (D) m_hist.push_back('0);
        m_filt  = '0;
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 0;
        m_idx   = 0;
        m_level = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] chg;
        logic [N-1:0] synced_before;
        int g;
        chg = m_filt ^ m_prev;
        g = -1;
        if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            bit lost;
            lost = 0;
            if (!enable_v[i]) begin
                m_pend[i] = 0;
            end else if (chg[i]) begin
                lost = m_pend[i] && (g != i);
                m_pend[i] = 1;
            end else if (g == i) begin
                m_pend[i] = 0;
            end
            if (lost) m_ovf[i] = 1;
            else if (ovc[i]) m_ovf[i] = 0;
        end
        if (!m_valid) begin
            if (g >= 0) begin
                m_valid = 1;
                m_idx   = g;
                m_level = m_filt[g];
            end
        end else if (ready_v) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % N;
        end
        m_prev = m_filt;
        synced_before = m_hist[D-1];
        m_hist.push_front(in_v);
        void'(m_hist.pop_back());
`ifdef SYNC_EVENT_ARBITER_DEBOUNCE_EN
        for (int i = 0; i < N; i++) begin
            if (synced_before[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= DC) begin
                    m_filt[i] = synced_before[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
`else
        m_filt = m_hist[D-1];
`endif
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // ---------------- compare process + accepted-event log ----------------
    always @(negedge clock) begin
        if (reset) begin
            check("valid", int'(event_valid), int'(m_valid));
            check("debug_state", int'(debug_state), int'(m_valid));
            if (m_valid) begin
                check("index", int'(event_index), m_idx);
                check("level", int'(event_level), int'(m_level));
            end
            check("pending", int'(pending), int'(m_pend));
            check("overflow", int'(overflow), int'(m_ovf));
            if (event_valid && ready_v) dut_log.push_back(int'(event_index));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_v     = '0;
        enable_v = '1;
        ovc      = '0;
        ready_v  = 1'b1;
        reset    = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        dut_log.delete();
    endtask

    task automatic measure_latency(input int bit_i, input int exp_lat, input string name);
        int k;
        k = 0;
        in_v[bit_i] = 1'b1;
        while (k < 40 && !event_valid) begin
            tick(1);
            k++;
        end
        check({name, "_latency"}, k, exp_lat);
        check({name, "_index"}, int'(event_index), bit_i);
        check({name, "_level"}, int'(event_level), 1);
        if (ready_v) begin
            tick(1);
            check({name, "_pulse_len"}, int'(event_valid), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        check("reset_valid", int'(event_valid), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_state", int'(debug_state), 0);

        // single rising edge, consumer always ready
        do_reset();
        measure_latency(2, SETTLE, "single");

        // three simultaneous edges, consumer stalls for 5 cycles
        do_reset();
        ready_v = 1'b0;
        in_v = 4'b1011;
        tick(SETTLE);
        check("stall_valid", int'(event_valid), 1);
        check("stall_index0", int'(event_index), 0);
        tick(4);
        check("stall_hold_valid", int'(event_valid), 1);
        check("stall_hold_index", int'(event_index), 0);
        check("stall_pending", int'(pending), 4'b1010);
        ready_v = 1'b1;
        tick(10);
        check("order_count", dut_log.size(), 3);
        if (dut_log.size() == 3) begin
            check("order_0", dut_log[0], 0);
            check("order_1", dut_log[1], 1);
            check("order_2", dut_log[2], 3);
        end

        // lost change on input 1, then clear
        do_reset();
        ready_v = 1'b0;
        in_v[1] = 1'b1;
        tick(SETTLE);
        check("ovf_presented", int'(event_index), 1);
        in_v[1] = 1'b0;
        tick(SETTLE);
        check("ovf_pending_before", int'(pending[1]), 1);
        check("ovf_before", int'(overflow[1]), 0);
        in_v[1] = 1'b1;
        tick(SETTLE);
        check("ovf_set", int'(overflow[1]), 1);
        check("ovf_pending_kept", int'(pending[1]), 1);
        ovc = 4'b0010;
        tick(1);
        ovc = '0;
        tick(1);
        check("ovf_cleared", int'(overflow[1]), 0);
        ready_v = 1'b1;
        tick(8);

        // disabled input produces nothing
        do_reset();
        enable_v = 4'b1011;
        for (int t = 0; t < 6; t++) begin
            in_v[2] = ~in_v[2];
            tick(SETTLE + 1);
            check("disabled_pending", int'(pending[2]), 0);
            check("disabled_valid", int'(event_valid), 0);
        end
        enable_v = '1;
        tick(SETTLE + 2);
        check("disabled_events", dut_log.size(), 0);

`ifdef SYNC_EVENT_ARBITER_DEBOUNCE_EN
        // short glitch is filtered, stable level gets through late
        do_reset();
        in_v[0] = 1'b1;
        tick(5);
        in_v[0] = 1'b0;
        tick(20);
        check("glitch_events", dut_log.size(), 0);
        check("glitch_valid", int'(event_valid), 0);
        measure_latency(0, SETTLE, "debounced");
`endif

        // reset while presenting, input still high afterwards
        do_reset();
        ready_v = 1'b0;
        in_v[3] = 1'b1;
        tick(SETTLE);
        check("rst_pre_valid", int'(event_valid), 1);
        reset = 1'b0;
        #1;
        check("rst_async_valid", int'(event_valid), 0);
        check("rst_async_pending", int'(pending), 0);
        check("rst_async_overflow", int'(overflow), 0);
        check("rst_async_state", int'(debug_state), 0);
        tick(2);
        ready_v = 1'b1;
        dut_log.delete();
        reset = 1'b1;
        measure_latency(3, SETTLE, "after_reset");
        tick(SETTLE + 4);
        check("after_reset_events", dut_log.size(), 1);

        // random traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) in_v[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) enable_v = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0) enable_v = '1;
            ready_v = ($urandom_range(0, 2) != 0);
            ovc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : '0;
            tick(1);
        end
        ready_v = 1'b1;
        ovc = '0;
        tick(SETTLE + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_event_arbiter.md
SYNC_EVENT_ARBITER -- requirements
Module: sync_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of asynchronous inputs, legal 1..16.
REQ-002 SHALL have parameter SYNC_DEPTH, default 2: synchronizer flops per input, legal 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 8: stable-cycle count for the debounce filter, legal 1..65535.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in, input, NUM_INPUTS bits: asynchronous level inputs.
REQ-007 SHALL have port enable, input, NUM_INPUTS bits: per-input event enable.
REQ-008 SHALL have port event_valid, output, 1 bit: an event is presented.
REQ-009 SHALL have port event_index, output, IW = max(1, clog2(NUM_INPUTS)) bits: source input of the presented event.
REQ-010 SHALL have port event_level, output, 1 bit: new filtered level of that input.
REQ-011 SHALL have port event_ready, input, 1 bit: consumer accepts the presented event.
REQ-012 SHALL have port pending, output, NUM_INPUTS bits: per-input unserved-change flags.
REQ-013 SHALL have port overflow, output, NUM_INPUTS bits: sticky lost-change flags.
REQ-014 SHALL have port overflow_clear, input, NUM_INPUTS bits: per-bit clear of overflow.

Function
REQ-015 SHALL pass each in bit through a SYNC_DEPTH-flop chain; the synchronized level is the last flop.
REQ-016 SHALL detect a change when the filtered level differs from its registered previous value.
REQ-017 SHALL set pending[i] on the edge after a change on input i only when enable[i]=1; a change with enable[i]=0 is discarded.
REQ-018 SHALL set overflow[i] when a change on input i occurs while pending[i]=1 and is not cleared that cycle; pending stays 1.
REQ-019 SHALL clear pending[i] whenever enable[i]=0, without retracting an event already presented.
REQ-020 SHALL implement FSM IDLE/PRESENT; in IDLE with any pending bit set, on the next edge it SHALL latch the selected index and its current filtered level, clear that pending bit, assert event_valid, and enter PRESENT.
REQ-021 SHALL select round-robin: the first set pending bit at or above pointer, wrapping modulo NUM_INPUTS; pointer resets to 0.
REQ-022 SHALL hold event_valid, event_index, event_level stable in PRESENT until an edge with event_ready=1, then deassert event_valid, set pointer to (index+1) mod NUM_INPUTS, and return to IDLE.
REQ-023 SHALL ignore event_ready while in IDLE; the peak rate is one event per 2 cycles.
REQ-024 SHALL, when the granted input changes again in the same cycle its pending bit is cleared, leave pending set (set wins), without setting overflow.
REQ-025 SHALL give overflow set priority over overflow_clear in the same cycle.
REQ-026 SHALL have an edge latency from the first clock edge sampling a new in level to event_valid=1 (IDLE, nothing else pending, filter bypassed) of SYNC_DEPTH+2 edges.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear all synchronizer flops, filtered and previous levels, debounce counters, pending, overflow, pointer, event_valid, event_index and event_level to 0, and force IDLE.
REQ-028 SHALL, if reset is asserted in PRESENT, drop the in-flight event; an input already high at reset release SHALL produce one rising event once synchronized.

Configuration
REQ-029 SHALL, with SYNC_EVENT_ARBITER_DEBOUNCE_EN defined, update the filtered level only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles (a per-input counter resets on any return to the filtered value), adding DEBOUNCE_CYCLES cycles of latency.
REQ-030 SHALL, without SYNC_EVENT_ARBITER_DEBOUNCE_EN, use the synchronized level directly as the filtered level, instantiate no counters, and ignore DEBOUNCE_CYCLES.

Verification
REQ-031 SHALL cover N=4, SYNC_DEPTH=2, no debounce: in[2] 0->1, event_ready=1 -> event_valid high for exactly 1 cycle 4 edges later, event_index=2, event_level=1.
REQ-032 SHALL cover in[0], in[1], in[3] rising in the same cycle with event_ready held 0 for 5 cycles, then 1 -> events in order 0, 1, 3; outputs stable while stalled.
REQ-033 SHALL cover in[1] toggling 0->1->0 while pending[1]=1 and stalled -> overflow[1]=1; overflow_clear[1] pulse -> overflow[1]=0.
REQ-034 SHALL cover enable[2]=0 and toggling in[2] -> no event; pending[2] stays 0.
REQ-035 SHALL cover a debounce build with DEBOUNCE_CYCLES=8: a 5-cycle glitch -> no event; a stable high level -> one event, latency 8 cycles longer than REQ-031.
REQ-036 SHALL cover reset pulled low in PRESENT -> event_valid=0 immediately (asynchronous), all flags 0.
